// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states and datapath widths.
package arith_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Width of the shared ripple add/subtract datapath
  localparam int ADDER_W   = 40;

  // Default operand width of the sequential divider
  localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/seq_divider32_if.sv
// Start/busy/done handshake and operand/result bus between issuing logic and the divider.
interface seq_divider32_if
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Issuing logic side
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/addsub40.sv
// 40-bit ripple-carry add/subtract built from a chain of full-adder cells.
// With sub=1 the b operand is inverted and the carry-in is 1, so sum = a - b
// and carry_out = 1 exactly when a >= b (unsigned).
module addsub40
  import arith_pkg::*;
(
  input  logic [ADDER_W-1:0] a,
  input  logic [ADDER_W-1:0] b,
  input  logic               sub,
  output logic [ADDER_W-1:0] sum,
  output logic               carry_out
);

  logic [ADDER_W:0]   carry;
  logic [ADDER_W-1:0] b_eff;

  assign b_eff    = b ^ {ADDER_W{sub}};
  assign carry[0] = sub;

  genvar gi;
  generate
    for (gi = 0; gi < ADDER_W; gi = gi + 1) begin : g_fa
      assign sum[gi]     = a[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
    end
  endgenerate

  assign carry_out = carry[ADDER_W];

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// A divisor of zero skips the iterations and reports all-ones / dividend.
module seq_divider32
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
)(
  input  logic             clk,
  input  logic             rst_n,
  seq_divider32_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dbz_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  logic [WIDTH:0]     shifted;
  logic [ADDER_W-1:0] add_a;
  logic [ADDER_W-1:0] add_b;
  logic [ADDER_W-1:0] add_sum;
  logic               add_carry;
  logic [WIDTH:0]     r_next;
  logic [WIDTH-1:0]   q_next;
  logic               last_iter;
  logic               unused_bits;

  // Partial remainder shifted left by one, pulling in the next dividend bit
  assign shifted = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign add_a   = ADDER_W'(shifted);
  assign add_b   = ADDER_W'(d_reg);

  addsub40 u_addsub (
    .a         (add_a),
    .b         (add_b),
    .sub       (1'b1),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

  // Carry-out set means the trial subtraction did not go negative
  assign r_next    = add_carry ? add_sum[WIDTH:0] : shifted;
  assign q_next    = {q_reg[WIDTH-2:0], add_carry};
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  // Upper adder bits and the partial-remainder MSB carry no information here
  assign unused_bits = ^{add_sum, r_reg[WIDTH]};

  // Control FSM, iteration datapath and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            q_reg    <= bus.dividend;
            d_reg    <= bus.divisor;
            r_reg    <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
            if (bus.divisor == '0) begin
              state_reg     <= S_DONE;
              done_reg      <= 1'b1;
              dbz_reg       <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend;
            end else begin
              state_reg <= S_RUN;
              dbz_reg   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_reg   <= r_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_iter) begin
            state_reg     <= S_DONE;
            done_reg      <= 1'b1;
            quotient_reg  <= q_next;
            remainder_reg <= r_next[WIDTH-1:0];
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;

endmodule

// File: doc/seq_divider32.md
Name: seq_divider32

Overview:
- Multi-cycle unsigned restoring divider: quotient = dividend / divisor and remainder = dividend % divisor, one quotient bit per clock.
- Inverse companion to the 32-bit Wallace-tree multiplier; shares the 40-bit ripple add/subtract datapath style.
- Sits beside the multiplier in the arithmetic unit and uses a start/busy/done handshake toward the issuing logic.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; legal range 2..39 (partial remainder WIDTH+1 must fit the 40-bit adder).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator; captured when start is accepted
- divisor  input  WIDTH  denominator; captured when start is accepted
- busy  output  1  high in RUN and DONE; start is ignored while high
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  registered flag, valid with done

Behaviour:
- Reset:
  - Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
  - On rst_n low: state=IDLE; busy, done, div_by_zero, quotient, remainder and counter all cleared to 0.
  - Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1, capture dividend into the Q shift register and divisor into the D register.
  - Clear the partial remainder R (WIDTH+1 bits) and the counter.
  - Next state is RUN, except divisor==0, where next state is DONE.
- RUN (one iteration per edge):
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {0,D}, computed by the 40-bit add/sub sub-module with zero-extended operands.
  - If T is non-negative (adder carry-out=1): R<=T and shift Q left inserting 1.
  - Otherwise: R<={R[WIDTH-1:0],Q[WIDTH-1]} and shift Q left inserting 0.
  - The counter increments. After the WIDTH-th iteration, next state is DONE.
- DONE:
  - done=1 for exactly one cycle.
  - quotient=Q and remainder=R[WIDTH-1:0] are registered on the edge entering DONE.
  - Next state is IDLE.
- Latency: start sampled at edge E0 -> iterations at E1..E32 -> done high in the cycle after E32. Total is WIDTH+1 edges from acceptance to done.
- Divide-by-zero:
  - Skips RUN; done is asserted in the cycle after E0.
  - quotient=all ones, remainder=dividend, div_by_zero=1.
  - div_by_zero is cleared on the next accepted start.
- Handshake:
  - start while busy=1 is ignored with no queuing; the operand registers are untouched.
  - start is accepted in the same cycle that IDLE is entered from DONE only on the following edge, i.e. the minimum issue interval is WIDTH+2 cycles.
- Results are held stable from done until the next accepted start's DONE. Outputs do not change during RUN.
- Arithmetic: unsigned only, no rounding, remainder < divisor always. dividend < divisor gives quotient=0 and remainder=dividend.

Decomposition:
- Shared package arith_pkg:
  - state enum (IDLE, RUN, DONE)
  - ADDER_W=40 constant
  - DIV_WIDTH=32 default constant
- One sub-module: addsub40.
  - Ports: 40-bit a, 40-bit b, sub select, 40-bit sum, carry-out.
  - Implemented as a ripple chain of the existing full-adder cells, with b inverted and carry-in=sub.
- FSM, counter and shift registers stay in seq_divider32.

Test Plan:
- Basic divide: dividend=100, divisor=7, start 1 cycle -> done exactly 33 edges later; quotient=14, remainder=2, div_by_zero=0, busy low the cycle after done.
- Maximum quotient: dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Also dividend=0xFFFFFFFF, divisor=0xFFFFFFFF -> quotient=1, remainder=0.
- Small over large: dividend=3, divisor=10 -> quotient=0, remainder=3.
- Divide-by-zero: dividend=5, divisor=0 -> done 1 cycle after acceptance; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Next op 9/3 clears the flag and gives quotient=3.
- Start while busy: start 100/7, then at edge 10 pulse start with 50/5 -> single done with 14/2; the second request is dropped and no second done occurs.
- Reset mid-op: start 1000/3, drop rst_n at edge 15 for 2 cycles -> all outputs 0, no done; a fresh start of 1000/3 yields quotient=333, remainder=1.
- Random regression: 10k random operand pairs checked against a golden model; divisor==0 is excluded except in a 1% directed mix.
